// File: rtl/program_loader.sv
// Framed byte-stream boot loader: SYNC, LEN, LEN data bytes, CSUM -> RAM[0..LEN-1], then releases CPU reset. Optional LOADER_TIMEOUT_EN adds an inter-byte timeout.
// Latency: outputs registered one edge after the accepting byte; rx_ready_o drops for the single WRITE cycle after each data byte.
module program_loader #(
  parameter int         ADDR_WIDTH     = 4,
  parameter int         DATA_WIDTH     = 8,
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 1000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            rx_data_i,
  input  logic                  rx_valid_i,
  output logic                  rx_ready_o,
  output logic                  ram_we_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_data_o,
  output logic                  cpu_reset_o,
  output logic                  load_active_o,
  output logic                  load_done_o,
  output logic                  load_error_o
);

  if (DATA_WIDTH != 8) begin : g_bad_data_width
    $error("program_loader: DATA_WIDTH must be 8");
  end
  if (ADDR_WIDTH < 1 || ADDR_WIDTH > 8) begin : g_bad_addr_width
    $error("program_loader: ADDR_WIDTH must be 1..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("program_loader: TIMEOUT_CYCLES must be at least 2");
  end

  localparam logic [8:0] MAX_LEN = (ADDR_WIDTH < 8) ? 9'(1 << ADDR_WIDTH) : 9'd255;

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_WRITE, S_CSUM, S_DONE, S_ERROR
  } state_t;

  state_t                r_state, w_state_nxt;
  logic [7:0]            r_len, w_len_nxt;
  logic [7:0]            r_count, w_count_nxt;
  logic [7:0]            r_acc, w_acc_nxt;
  logic                  r_we, w_we_nxt;
  logic [ADDR_WIDTH-1:0] r_addr, w_addr_nxt;
  logic [DATA_WIDTH-1:0] r_data, w_data_nxt;
  logic                  r_cpu_reset, w_cpu_reset_nxt;
  logic                  r_active, w_active_nxt;
  logic                  r_done, w_done_nxt;
  logic                  r_error, w_error_nxt;

  logic w_accept;
  logic w_in_frame;
  logic w_tmo_hit;

  assign rx_ready_o = (r_state != S_WRITE);
  assign w_accept   = rx_valid_i && rx_ready_o;
  assign w_in_frame = (r_state == S_LEN) || (r_state == S_DATA) ||
                      (r_state == S_WRITE) || (r_state == S_CSUM);

`ifdef LOADER_TIMEOUT_EN
  localparam int TMO_W = $clog2(TIMEOUT_CYCLES);
  logic [TMO_W-1:0] r_tmo;

  assign w_tmo_hit = (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_tmo <= '0;
    end else if (w_accept || !w_in_frame) begin
      r_tmo <= '0;
    end else if (!w_tmo_hit) begin
      r_tmo <= r_tmo + TMO_W'(1);
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_comb begin
    w_state_nxt     = r_state;
    w_len_nxt       = r_len;
    w_count_nxt     = r_count;
    w_acc_nxt       = r_acc;
    w_we_nxt        = 1'b0;
    w_addr_nxt      = r_addr;
    w_data_nxt      = r_data;
    w_active_nxt    = r_active;
    w_done_nxt      = r_done;
    w_error_nxt     = r_error;
    w_cpu_reset_nxt = 1'b1;

    case (r_state)
      S_IDLE, S_DONE, S_ERROR: begin
        if (w_accept && rx_data_i == SYNC_BYTE) begin
          w_state_nxt  = S_LEN;
          w_count_nxt  = '0;
          w_acc_nxt    = '0;
          w_active_nxt = 1'b1;
          w_done_nxt   = 1'b0;
          w_error_nxt  = 1'b0;
        end
      end
      S_LEN: begin
        if (w_accept) begin
          if (rx_data_i == 8'd0 || {1'b0, rx_data_i} > MAX_LEN) begin
            w_state_nxt  = S_ERROR;
            w_error_nxt  = 1'b1;
            w_active_nxt = 1'b0;
          end else begin
            w_len_nxt   = rx_data_i;
            w_state_nxt = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_accept) begin
          w_addr_nxt  = r_count[ADDR_WIDTH-1:0];
          w_data_nxt  = rx_data_i;
          w_we_nxt    = 1'b1;
          w_acc_nxt   = r_acc + rx_data_i;
          w_state_nxt = S_WRITE;
        end
      end
      S_WRITE: begin
        // RAM captures on this edge; the count advances alongside it.
        w_count_nxt = r_count + 8'd1;
        if (({1'b0, r_count} + 9'd1) < {1'b0, r_len}) begin
          w_state_nxt = S_DATA;
        end else begin
          w_state_nxt = S_CSUM;
        end
      end
      S_CSUM: begin
        if (w_accept) begin
          w_active_nxt = 1'b0;
          if (rx_data_i == r_acc) begin
            w_state_nxt = S_DONE;
            w_done_nxt  = 1'b1;
          end else begin
            w_state_nxt = S_ERROR;
            w_error_nxt = 1'b1;
          end
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase

    if (w_tmo_hit && w_in_frame && !w_accept) begin
      w_state_nxt  = S_ERROR;
      w_error_nxt  = 1'b1;
      w_active_nxt = 1'b0;
    end

    w_cpu_reset_nxt = (w_state_nxt != S_DONE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_len       <= '0;
      r_count     <= '0;
      r_acc       <= '0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_data      <= '0;
      r_cpu_reset <= 1'b1;
      r_active    <= 1'b0;
      r_done      <= 1'b0;
      r_error     <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_len       <= w_len_nxt;
      r_count     <= w_count_nxt;
      r_acc       <= w_acc_nxt;
      r_we        <= w_we_nxt;
      r_addr      <= w_addr_nxt;
      r_data      <= w_data_nxt;
      r_cpu_reset <= w_cpu_reset_nxt;
      r_active    <= w_active_nxt;
      r_done      <= w_done_nxt;
      r_error     <= w_error_nxt;
    end
  end

  assign ram_we_o      = r_we;
  assign ram_addr_o    = r_addr;
  assign ram_data_o    = r_data;
  assign cpu_reset_o   = r_cpu_reset;
  assign load_active_o = r_active;
  assign load_done_o   = r_done;
  assign load_error_o  = r_error;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: directed frames, randomized frames against a frame-level model, reset and timeout cases.
module tb_program_loader;
  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [7:0]    rx_data_i = 8'h00;
  logic          rx_valid_i = 1'b0;
  logic          rx_ready_o;
  logic          ram_we_o;
  logic [AW-1:0] ram_addr_o;
  logic [7:0]    ram_data_o;
  logic          cpu_reset_o;
  logic          load_active_o;
  logic          load_done_o;
  logic          load_error_o;

  program_loader #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(8), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(20)
  ) dut (
    .clk(clk), .reset(reset),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .ram_we_o(ram_we_o), .ram_addr_o(ram_addr_o), .ram_data_o(ram_data_o),
    .cpu_reset_o(cpu_reset_o), .load_active_o(load_active_o),
    .load_done_o(load_done_o), .load_error_o(load_error_o)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int wr_cnt = 0;
  int cyc    = 0;
  logic [7:0] ram     [DEPTH] = '{default: 8'h00};
  logic [7:0] exp_ram [DEPTH] = '{default: 8'h00};

  localparam logic [17:0] RESET_VEC = {1'b1, 1'b0, 4'h0, 8'h00, 4'b1000};

  // Behaves like the downstream RAM: captures on the clock edge that closes a write strobe.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (ram_we_o) begin
      ram[ram_addr_o] <= ram_data_o;
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited;
    if (gap > 0) begin
      rx_valid_i = 1'b0;
      repeat (gap) @(negedge clk);
    end
    rx_valid_i = 1'b1;
    rx_data_i  = b;
    waited = 0;
    while (rx_ready_o !== 1'b1 && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (rx_ready_o !== 1'b1) begin
      checks++; errors++;
      $display("FAIL send_wait: rx_ready_o stuck at %b, required 1", rx_ready_o);
    end else begin
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    logic [17:0] got;
    reset = 1'b1;
    #1 reset = 1'b0;
    repeat (3) @(negedge clk);
    got = {rx_ready_o, ram_we_o, ram_addr_o, ram_data_o, cpu_reset_o, load_active_o, load_done_o, load_error_o};
    checks++;
    if (got !== RESET_VEC) begin
      errors++; $display("FAIL reset_hold: got %h required %h", got, RESET_VEC);
    end
    reset = 1'b1;
    @(negedge clk);
    got = {rx_ready_o, ram_we_o, ram_addr_o, ram_data_o, cpu_reset_o, load_active_o, load_done_o, load_error_o};
    checks++;
    if (got !== RESET_VEC) begin
      errors++; $display("FAIL reset_release: got %h required %h", got, RESET_VEC);
    end
  endtask

  task automatic test_basic;
    int w0;
    w0 = wr_cnt;
    send_byte(8'hA5, 0);
    checks++;
    if ({load_active_o, cpu_reset_o} !== 2'b11) begin
      errors++; $display("FAIL basic_sync: active,cpu_reset=%b required 11", {load_active_o, cpu_reset_o});
    end
    send_byte(8'h03, 0);
    send_byte(8'h10, 0); exp_ram[0] = 8'h10;
    send_byte(8'h20, 0); exp_ram[1] = 8'h20;
    send_byte(8'h30, 0); exp_ram[2] = 8'h30;
    checks++;
    if ({load_done_o, cpu_reset_o} !== 2'b01) begin
      errors++; $display("FAIL basic_pre_csum: done,cpu_reset=%b required 01", {load_done_o, cpu_reset_o});
    end
    send_byte(8'h60, 0);
    rx_valid_i = 1'b0;
    checks++;
    if ({load_done_o, cpu_reset_o, load_error_o, load_active_o} !== 4'b1000) begin
      errors++; $display("FAIL basic_done: done,cpu_reset,error,active=%b required 1000",
                         {load_done_o, cpu_reset_o, load_error_o, load_active_o});
    end
    checks++;
    if (wr_cnt - w0 !== 3) begin
      errors++; $display("FAIL basic_writes: got %0d required 3", wr_cnt - w0);
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (ram[i] !== exp_ram[i]) begin
        errors++; $display("FAIL basic_ram[%0d]: got %h required %h", i, ram[i], exp_ram[i]);
      end
    end
  endtask

  task automatic test_garbage;
    send_byte(8'h00, 0);
    send_byte(8'hFF, 1);
    send_byte(8'h12, 0);
    checks++;
    if (load_done_o !== 1'b1) begin
      errors++; $display("FAIL garbage_ignored: done=%b required 1", load_done_o);
    end
    send_byte(8'hA5, 0);
    checks++;
    if ({load_done_o, cpu_reset_o} !== 2'b01) begin
      errors++; $display("FAIL garbage_resync: done,cpu_reset=%b required 01", {load_done_o, cpu_reset_o});
    end
    send_byte(8'h01, 0);
    send_byte(8'h7E, 0); exp_ram[0] = 8'h7E;
    checks++;
    if (rx_ready_o !== 1'b0) begin
      errors++; $display("FAIL write_stall: rx_ready_o=%b required 0", rx_ready_o);
    end
    rx_valid_i = 1'b0;
    @(negedge clk);
    checks++;
    if (rx_ready_o !== 1'b1) begin
      errors++; $display("FAIL write_one_cycle: rx_ready_o=%b required 1", rx_ready_o);
    end
    send_byte(8'h7E, 0);
    rx_valid_i = 1'b0;
    checks++;
    if ({load_done_o, ram[0]} !== {1'b1, 8'h7E}) begin
      errors++; $display("FAIL garbage_done: done,ram0=%h required 17e", {load_done_o, ram[0]});
    end
  endtask

  task automatic test_bad_csum;
    send_byte(8'hA5, 0);
    send_byte(8'h02, 0);
    send_byte(8'h01, 0); exp_ram[0] = 8'h01;
    send_byte(8'h02, 0); exp_ram[1] = 8'h02;
    send_byte(8'h04, 0);
    rx_valid_i = 1'b0;
    checks++;
    if ({load_error_o, load_done_o, cpu_reset_o, load_active_o} !== 4'b1010) begin
      errors++; $display("FAIL bad_csum: error,done,cpu_reset,active=%b required 1010",
                         {load_error_o, load_done_o, cpu_reset_o, load_active_o});
    end
    checks++;
    if ({ram[0], ram[1]} !== 16'h0102) begin
      errors++; $display("FAIL bad_csum_partial: ram0,1=%h required 0102", {ram[0], ram[1]});
    end
    send_byte(8'hA5, 2);
    checks++;
    if (load_error_o !== 1'b0) begin
      errors++; $display("FAIL error_clear: error=%b required 0", load_error_o);
    end
    send_byte(8'h01, 0);
    send_byte(8'h05, 0); exp_ram[0] = 8'h05;
    send_byte(8'h05, 0);
    rx_valid_i = 1'b0;
    checks++;
    if ({load_done_o, cpu_reset_o, ram[0]} !== {2'b10, 8'h05}) begin
      errors++; $display("FAIL recover_done: done,cpu_reset,ram0=%h required 205", {load_done_o, cpu_reset_o, ram[0]});
    end
  endtask

  task automatic test_len_errors;
    int w0;
    logic [7:0] lens [2] = '{8'h00, 8'h11};
    for (int k = 0; k < 2; k++) begin
      w0 = wr_cnt;
      send_byte(8'hA5, 0);
      send_byte(lens[k], 0);
      rx_valid_i = 1'b0;
      checks++;
      if ({load_error_o, cpu_reset_o, load_active_o} !== 3'b110) begin
        errors++; $display("FAIL len_error[%h]: error,cpu_reset,active=%b required 110",
                           lens[k], {load_error_o, cpu_reset_o, load_active_o});
      end
      repeat (3) @(negedge clk);
      checks++;
      if (wr_cnt !== w0) begin
        errors++; $display("FAIL len_nowrite[%h]: writes %0d required 0", lens[k], wr_cnt - w0);
      end
    end
  endtask

  // Frame-level model: a legal length writes every data byte to its index; done iff checksum matches.
  task automatic test_random;
    int len, npre, gmax, w0;
    bit bad, ok_len, exp_done;
    logic [7:0] b, sum;
    for (int f = 0; f < 30; f++) begin
      len  = $urandom_range(0, 19);
      bad  = ($urandom_range(0, 3) == 0);
      npre = $urandom_range(0, 2);
      gmax = $urandom_range(0, 3);
      ok_len = (len >= 1 && len <= DEPTH);
      sum = 8'h00;
      w0 = wr_cnt;
      for (int p = 0; p < npre; p++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        send_byte(b, $urandom_range(0, gmax));
      end
      send_byte(8'hA5, $urandom_range(0, gmax));
      checks++;
      if ({load_active_o, load_done_o, load_error_o, cpu_reset_o} !== 4'b1001) begin
        errors++; $display("FAIL rand_sync[%0d]: active,done,error,cpu_reset=%b required 1001",
                           f, {load_active_o, load_done_o, load_error_o, cpu_reset_o});
      end
      send_byte(8'(len), $urandom_range(0, gmax));
      if (ok_len) begin
        for (int i = 0; i < len; i++) begin
          b = 8'($urandom_range(0, 255));
          sum = sum + b;
          exp_ram[i] = b;
          send_byte(b, $urandom_range(0, gmax));
        end
        if (bad) sum = sum ^ 8'($urandom_range(1, 255));
        send_byte(sum, $urandom_range(0, gmax));
      end
      rx_valid_i = 1'b0;
      exp_done = ok_len && !bad;
      checks++;
      if ({load_done_o, load_error_o, cpu_reset_o, load_active_o} !== {exp_done, !exp_done, !exp_done, 1'b0}) begin
        errors++; $display("FAIL rand_status[%0d]: done,error,cpu_reset,active=%b required %b", f,
                           {load_done_o, load_error_o, cpu_reset_o, load_active_o}, {exp_done, !exp_done, !exp_done, 1'b0});
      end
      checks++;
      if (wr_cnt - w0 !== (ok_len ? len : 0)) begin
        errors++; $display("FAIL rand_writes[%0d]: got %0d required %0d", f, wr_cnt - w0, ok_len ? len : 0);
      end
      for (int i = 0; i < DEPTH; i++) begin
        checks++;
        if (ram[i] !== exp_ram[i]) begin
          errors++; $display("FAIL rand_ram[%0d][%0d]: got %h required %h", f, i, ram[i], exp_ram[i]);
        end
      end
    end
  endtask

  // Valid held high throughout: each byte consumed once, one data byte per two cycles.
  task automatic test_back_to_back;
    int len, c0;
    logic [7:0] b, sum;
    for (int f = 0; f < 3; f++) begin
      len = $urandom_range(1, DEPTH);
      sum = 8'h00;
      c0 = cyc;
      send_byte(8'hA5, 0);
      send_byte(8'(len), 0);
      for (int i = 0; i < len; i++) begin
        b = 8'($urandom_range(0, 255));
        sum = sum + b;
        exp_ram[i] = b;
        send_byte(b, 0);
      end
      send_byte(sum, 0);
      rx_valid_i = 1'b0;
      checks++;
      if (cyc - c0 !== 2 * len + 3) begin
        errors++; $display("FAIL b2b_cycles[%0d]: got %0d required %0d", f, cyc - c0, 2 * len + 3);
      end
      checks++;
      if (load_done_o !== 1'b1) begin
        errors++; $display("FAIL b2b_done[%0d]: done=%b required 1", f, load_done_o);
      end
      for (int i = 0; i < len; i++) begin
        checks++;
        if (ram[i] !== exp_ram[i]) begin
          errors++; $display("FAIL b2b_ram[%0d][%0d]: got %h required %h", f, i, ram[i], exp_ram[i]);
        end
      end
    end
  endtask

  task automatic test_reset_midframe;
    int w0;
    logic [17:0] got;
    send_byte(8'hA5, 0);
    checks++;
    if ({cpu_reset_o, load_done_o} !== 2'b10) begin
      errors++; $display("FAIL mid_sync: cpu_reset,done=%b required 10", {cpu_reset_o, load_done_o});
    end
    send_byte(8'h02, 0);
    send_byte(8'hAA, 0);
    w0 = wr_cnt;
    rx_data_i = 8'h33;
    reset = 1'b0;
    #1;
    got = {rx_ready_o, ram_we_o, ram_addr_o, ram_data_o, cpu_reset_o, load_active_o, load_done_o, load_error_o};
    checks++;
    if (got !== RESET_VEC) begin
      errors++; $display("FAIL mid_reset_async: got %h required %h", got, RESET_VEC);
    end
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt !== w0 || ram[0] !== exp_ram[0]) begin
      errors++; $display("FAIL mid_reset_nowrite: writes %0d ram0 %h required 0 and %h", wr_cnt - w0, ram[0], exp_ram[0]);
    end
    rx_valid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    got = {rx_ready_o, ram_we_o, ram_addr_o, ram_data_o, cpu_reset_o, load_active_o, load_done_o, load_error_o};
    checks++;
    if (got !== RESET_VEC) begin
      errors++; $display("FAIL mid_reset_release: got %h required %h", got, RESET_VEC);
    end
    send_byte(8'hA5, 0);
    send_byte(8'h01, 0);
    send_byte(8'h42, 0); exp_ram[0] = 8'h42;
    send_byte(8'h42, 0);
    rx_valid_i = 1'b0;
    checks++;
    if ({load_done_o, ram[0]} !== {1'b1, 8'h42}) begin
      errors++; $display("FAIL mid_reset_reload: done,ram0=%h required 142", {load_done_o, ram[0]});
    end
  endtask

  task automatic test_timeout;
    int n;
    send_byte(8'hA5, 0);
    rx_valid_i = 1'b0;
`ifdef LOADER_TIMEOUT_EN
    n = 0;
    while (load_error_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n !== 20) begin
      errors++; $display("FAIL timeout_cycles: error after %0d cycles required 20", n);
    end
`else
    n = 1000;
    repeat (n) @(negedge clk);
    checks++;
    if ({load_active_o, load_error_o} !== 2'b10) begin
      errors++; $display("FAIL no_timeout: active,error=%b required 10 after %0d cycles", {load_active_o, load_error_o}, n);
    end
`endif
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_garbage();
    test_bad_csum();
    test_len_errors();
    test_random();
    test_back_to_back();
    test_reset_midframe();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
